// File: rtl/uart_pkg.sv
// Shared types and helpers for the word-wide UART transmitter.
//   uart_state_e             : transmitter FSM states
//   CLKS_PER_BIT_115200_50M  : baud divisor for 115200 baud from a 50 MHz clock
//   frame_bits()             : serial bits per byte frame (start + data + parity + stop)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int unsigned CLKS_PER_BIT_115200_50M = 434;

    function automatic int unsigned frame_bits(input int unsigned stop_bits, input bit parity_en);
        return 32'd9 + 32'(parity_en) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: counts 0..CLKS_PER_BIT-1 and wraps.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   clr        : synchronous clear, holds the counter at 0
//   tick_c     : high in the last cycle of each bit period
//   pre_tick_c : high in the second-to-last cycle of each bit period
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_c,
    output logic pre_tick_c
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_c     = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign pre_tick_c = (cnt_q == CW'(CLKS_PER_BIT - 2));

    // Next count: wrap on the tick, hold at 0 while cleared
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// Multi-byte UART transmitter: latches a DATA_BYTES-wide word on start and
// sends it as back-to-back 8N1-style frames, byte 0 first, each byte LSB first.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   start   : word request, taken only in IDLE
//   data_in : word to send, byte 0 in bits [7:0]
//   tx      : serial line, idles high
//   busy    : high while a word is on the line
//   done    : one-cycle pulse in the final cycle of the last stop bit
// Compile-time option: define UART_PARITY_EN to append a parity bit to every byte.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BYTES   = 8,
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200_50M,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8*DATA_BYTES-1:0] data_in,
    output logic                    tx,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned WW = 8 * DATA_BYTES;
    localparam int unsigned BW = $clog2(DATA_BYTES) + 1;

    // Elaboration-time parameter legality checks
    if (DATA_BYTES < 1 || DATA_BYTES > 16) begin : g_bad_bytes
        $error("uart_word_tx: DATA_BYTES must be 1..16");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_word_tx: CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_word_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_par
        $error("uart_word_tx: PARITY_ODD must be 0 or 1");
    end

    uart_state_e   state_q, state_d;
    logic [WW-1:0] shift_q, shift_d;
    logic [BW-1:0] byte_idx_q, byte_idx_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          tick_c;
    logic          pre_tick_c;
    logic          baud_clr_c;
    logic [7:0]    cur_byte_c;
    logic          last_stop_c;
    logic          last_byte_c;

    // Counter is parked at 0 in IDLE so every word starts with a fresh bit phase
    assign baud_clr_c  = (state_q == IDLE);
    assign cur_byte_c  = shift_q[7:0];
    assign last_stop_c = (bit_idx_q == 3'(STOP_BITS - 1));
    assign last_byte_c = (byte_idx_q == BW'(DATA_BYTES - 1));

`ifdef UART_PARITY_EN
    logic parity_bit_c;
    assign parity_bit_c = (^cur_byte_c) ^ 1'(PARITY_ODD);
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk        (clk),
        .rst        (rst),
        .clr        (baud_clr_c),
        .tick_c     (tick_c),
        .pre_tick_c (pre_tick_c)
    );

    // Next-state and registered-output logic; tx_d is the line level for the next cycle
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    state_d    = START;
                    shift_d    = data_in;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (tick_c) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = cur_byte_c[0];
                end
            end
            DATA: begin
                if (tick_c) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_bit_c;
`else
                        state_d   = STOP;
                        bit_idx_d = '0;
                        tx_d      = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = cur_byte_c[bit_idx_d];
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (tick_c) begin
                    state_d   = STOP;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end
            end
`endif
            STOP: begin
                // Registered done must already be high in the final cycle
                if (last_stop_c && last_byte_c && pre_tick_c) begin
                    done_d = 1'b1;
                end
                if (tick_c) begin
                    if (!last_stop_c) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else if (last_byte_c) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                    end else begin
                        state_d    = START;
                        byte_idx_d = byte_idx_q + BW'(1);
                        shift_d    = shift_q >> 8;
                        tx_d       = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx (8 bytes, 4 clocks per bit, 1 stop bit).
module tb_uart_word_tx;

    localparam int unsigned DB   = 8;
    localparam int unsigned CPB  = 4;
    localparam int unsigned SB   = 1;
    localparam int unsigned PODD = 1;
`ifdef UART_PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif
    localparam int unsigned FB = 1 + 8 + P + SB;
    localparam int          W  = int'(DB * FB * CPB);

    logic          clk;
    logic          rst;
    logic          start;
    logic [63:0]   data_in;
    logic          tx;
    logic          busy;
    logic          done;

    int n_checks;
    int n_fail;

    uart_word_tx #(
        .DATA_BYTES   (DB),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (SB),
        .PARITY_ODD   (PODD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Serial line level for bit number idx of the word's bit stream
    function automatic logic exp_bit(input logic [63:0] word, input int idx);
        int   frame;
        int   pos;
        logic [7:0] b;
        frame = idx / int'(FB);
        pos   = idx % int'(FB);
        b     = word[frame*8 +: 8];
        if (pos == 0)
            return 1'b0;
        if (pos <= 8)
            return b[pos-1];
        if (P == 1 && pos == 9)
            return (^b) ^ (PODD == 1);
        return 1'b1;
    endfunction

    // Caller is at a negedge with the DUT idle; the next posedge accepts the word.
    // Returns at the negedge of the idle cycle following done.
    task automatic run_word(input logic [63:0] word, input bit hold, input bit poke_mid);
        int dones;
        dones   = 0;
        data_in = word;
        start   = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            check_eq("tx", 32'(tx), 32'(exp_bit(word, (i - 1) / int'(CPB))));
            check_eq("busy", 32'(busy), 32'd1);
            check_eq("done", 32'(done), 32'(i == W));
            if (done === 1'b1) dones++;
            if (poke_mid && i == W / 2) begin
                start   = 1'b1;
                data_in = ~word;
            end
            if (poke_mid && i == W / 2 + 1) start = 1'b0;
            @(negedge clk);
        end
        check_eq("idle_tx", 32'(tx), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_done", 32'(done), 32'd0);
        check_eq("done_count", 32'(dones), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b1;
        data_in  = 64'hDEAD_BEEF_0123_4567;

        // Reset held with start high: nothing accepted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_tx", 32'(tx), 32'd1);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_done", 32'(done), 32'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        check_eq("post_rst_tx", 32'(tx), 32'd1);

        // Directed word
        run_word(64'hA1A34D6FF6B2C581, 1'b0, 1'b0);

        // start held high: two words with one idle cycle between them
        run_word(64'h4423_3E79_4794_27F7, 1'b1, 1'b0);
        run_word(64'h4423_3E79_4794_27F7, 1'b0, 1'b0);

        // start pulsed mid-word is ignored
        run_word({$urandom, $urandom}, 1'b0, 1'b1);

        // Reset in the middle of a word
        begin
            logic [63:0] w;
            w       = {$urandom, $urandom};
            data_in = w;
            start   = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 1; i <= 100; i++) begin
                check_eq("pre_rst_tx", 32'(tx), 32'(exp_bit(w, (i - 1) / int'(CPB))));
                if (i < 100) @(negedge clk);
            end
            rst = 1'b1;
            @(negedge clk);
            check_eq("midrst_tx", 32'(tx), 32'd1);
            check_eq("midrst_busy", 32'(busy), 32'd0);
            check_eq("midrst_done", 32'(done), 32'd0);
            rst = 1'b0;
            @(negedge clk);
            check_eq("after_rst_busy", 32'(busy), 32'd0);
        end
        run_word({$urandom, $urandom}, 1'b0, 1'b0);

        // Randomized words, some with a stray start mid-word
        for (int k = 0; k < 6; k++) begin
            run_word({$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check_eq("gap_tx", 32'(tx), 32'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
